ddr3_host_port: RTL and testbench
=================================

DDR3_HOST_PORT -- requirements
Module: ddr3_host_port

Interface
REQ-001 Parameter NOP_CMD, default 3'b000, is the idle command code driven on cmd when no command is issued.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid/req_ready  in/out  1/1  client request handshake; a request transfers when both are high.
REQ-005 req_cmd, req_addr, req_sz, req_op  in  3/26/2/3  request fields; cmd codes: SCR=1, SCW=2, BLR=3, BLW=4, ATR=5, ATW=6.
REQ-006 wdata_valid/wdata_ready/wdata  in/out/in  1/1/16  client write-data handshake.
REQ-007 rsp_valid/rsp_ready/rsp_data/rsp_addr  out/in/out/out  1/1/16/26  client read-response handshake.
REQ-008 cmd, addr, sz, op, din  out  3/26/2/3/16  controller command and write-data port.
REQ-009 ready, notfull  in  1/1  controller initialised / command FIFO not full.
REQ-010 fillcount  in  6  controller input-data FIFO occupancy, 0..32; 32 means full.
REQ-011 validout, dout, raddr  in  1/16/26  controller return FIFO non-empty (registered), head data, head address.
REQ-012 read  out  1  pop strobe to the controller return FIFO.

Function
REQ-013 States: IDLE, COLLECT, ISSUE, BURST; req_ready SHALL be 1 only in IDLE with ready=1.
REQ-014 On request transfer, the fields SHALL be registered; BLW -> COLLECT; every other code -> ISSUE; illegal codes (0, 7) SHALL be dropped and stay in IDLE.
REQ-015 COLLECT: wdata_ready=1; each transferred word SHALL be written to a 32x16 burst buffer; after exactly (sz+1)*8 words (8/16/24/32) -> ISSUE.
REQ-016 ISSUE, read types (SCR, BLR): drive cmd/addr/sz/op for one cycle when notfull=1, then -> IDLE.
REQ-017 ISSUE, SCW/ATW/ATR: require notfull=1, fillcount<32 and wdata_valid=1; that cycle drive cmd fields, din=wdata, pulse wdata_ready; then -> IDLE.
REQ-018 ISSUE, BLW: require notfull=1 and fillcount<32; drive cmd fields with din=buffer[0]; then -> BURST with index=1.
REQ-019 BURST: cmd=NOP_CMD, din=buffer[index]; index SHALL advance only on cycles with fillcount!=32; after index (sz+1)*8-1 is presented on an advancing cycle -> IDLE.
REQ-020 cmd SHALL equal NOP_CMD on every cycle not covered by REQ-016..018; a command SHALL never be driven for more than one cycle.
REQ-021 Return path: when validout=1, no pop was issued in the previous cycle, and (rsp_valid=0 or rsp_ready=1), assert read for one cycle and register dout->rsp_data, raddr->rsp_addr, set rsp_valid=1 next cycle.
REQ-022 rsp_valid SHALL clear when rsp_ready=1 and no new capture occurs that cycle; simultaneous consume and capture SHALL keep rsp_valid=1 with new data.
REQ-023 read SHALL never assert in two consecutive cycles (validout lags the pop by one cycle).
REQ-024 Command and return paths SHALL operate independently and concurrently.
REQ-025 ready dropping to 0 SHALL only block new request acceptance; an in-flight ISSUE/BURST SHALL complete.

Reset
REQ-026 During reset: state=IDLE, req_ready=0, wdata_ready=0, rsp_valid=0, read=0, cmd=NOP_CMD, addr=0, sz=0, op=0, din=0, rsp_data=0, rsp_addr=0, burst index and word counters=0.
REQ-027 Reset mid-COLLECT or mid-BURST SHALL discard buffered data and the pending request, with no further cmd or data output.

Verification
REQ-028 SCR addr=0x0000123, notfull=1 -> cmd=1, addr=0x0000123 for exactly one cycle, two cycles after the req transfer; then NOP.
REQ-029 BLW sz=1 with 16 words 0x0100..0x010F, fillcount=5 -> cmd=4 with din=0x0100, then 15 NOP cycles with din=0x0101..0x010F in order.
REQ-030 BLW sz=0 with fillcount held at 32 for 3 cycles during BURST -> din holds the same word for 3 cycles; 8 words total, with none skipped or repeated.
REQ-031 SCW with notfull=0 for 4 cycles -> cmd stays NOP and wdata_ready=0; the command issues on the first cycle with notfull=1.
REQ-032 validout=1 with 3 return entries and rsp_ready=1 -> read pulses separated by at least one idle cycle; rsp_data/rsp_addr match dout/raddr in order.
REQ-033 Reset asserted at BURST index 4 -> the next cycle shows state IDLE, cmd=NOP, rsp_valid=0, and no controller activity until a new request.

Source files
------------

// File: rtl/ddr3_host_port.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_host_port
//  Function : Client-side host port for a DDR3 controller: request capture,
//             write-burst buffering, command issue and read-return handling.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr3_host_port #(
  parameter logic [2:0] NOP_CMD = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  // client request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [25:0] req_addr,
  input  logic [1:0]  req_sz,
  input  logic [2:0]  req_op,
  // client write data
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [15:0] wdata,
  // client read response
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [25:0] rsp_addr,
  // controller command / write data
  output logic [2:0]  cmd,
  output logic [25:0] addr,
  output logic [1:0]  sz,
  output logic [2:0]  op,
  output logic [15:0] din,
  input  logic        ready,
  input  logic        notfull,
  input  logic [5:0]  fillcount,
  // controller return FIFO
  input  logic        validout,
  input  logic [15:0] dout,
  input  logic [25:0] raddr,
  output logic        read
);

  localparam logic [2:0] c_CMD_SCR = 3'd1;
  localparam logic [2:0] c_CMD_SCW = 3'd2;
  localparam logic [2:0] c_CMD_BLR = 3'd3;
  localparam logic [2:0] c_CMD_BLW = 3'd4;
  localparam logic [2:0] c_CMD_ATR = 3'd5;
  localparam logic [2:0] c_CMD_ATW = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_ISSUE   = 2'd2,
    S_BURST   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [2:0]  r_req_cmd;
  logic [25:0] r_req_addr;
  logic [1:0]  r_req_sz;
  logic [2:0]  r_req_op;
  logic [4:0]  r_idx;
  logic [15:0] r_buf [0:31];

  logic [2:0]  r_cmd;
  logic [25:0] r_addr;
  logic [1:0]  r_sz;
  logic [2:0]  r_op;
  logic [15:0] r_din;

  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic [25:0] r_rsp_addr;
  logic        r_read_d;

  logic        w_req_legal;
  logic        w_req_xfer;
  logic        w_collect_xfer;
  logic        w_fifo_room;
  logic        w_fifo_full;
  logic        w_last_idx;
  logic        w_is_read;
  logic        w_is_wsingle;
  logic        w_is_blw;
  logic        w_issue_rd;
  logic        w_issue_ws;
  logic        w_issue_blw;
  logic        w_issue;
  logic        w_req_ready;
  logic        w_wdata_ready;
  logic        w_pop;

  assign w_req_legal  = (req_cmd != 3'd0) && (req_cmd != 3'd7);
  assign w_fifo_full  = (fillcount == 6'd32);
  assign w_fifo_room  = (fillcount < 6'd32);
  // burst length is (sz+1)*8, so the last index is simply {sz, 3'b111}
  assign w_last_idx   = (r_idx == {r_req_sz, 3'b111});
  assign w_is_read    = (r_req_cmd == c_CMD_SCR) || (r_req_cmd == c_CMD_BLR);
  assign w_is_wsingle = (r_req_cmd == c_CMD_SCW) || (r_req_cmd == c_CMD_ATW) ||
                        (r_req_cmd == c_CMD_ATR);
  assign w_is_blw     = (r_req_cmd == c_CMD_BLW);

  always_comb begin
    w_state_nxt   = r_state;
    w_req_ready   = 1'b0;
    w_wdata_ready = 1'b0;
    w_issue_rd    = 1'b0;
    w_issue_ws    = 1'b0;
    w_issue_blw   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = ready;
        if (req_valid && ready && w_req_legal)
          w_state_nxt = (req_cmd == c_CMD_BLW) ? S_COLLECT : S_ISSUE;
      end
      S_COLLECT: begin
        w_wdata_ready = 1'b1;
        if (wdata_valid && w_last_idx)
          w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_issue_rd    = w_is_read && notfull;
        w_issue_ws    = w_is_wsingle && notfull && w_fifo_room && wdata_valid;
        w_issue_blw   = w_is_blw && notfull && w_fifo_room;
        w_wdata_ready = w_issue_ws;
        if (w_issue_blw)
          w_state_nxt = S_BURST;
        else if (w_issue_rd || w_issue_ws)
          w_state_nxt = S_IDLE;
      end
      S_BURST: begin
        if (!w_fifo_full && w_last_idx)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // client-facing strobes stay quiet for the whole reset cycle
    if (reset) begin
      w_req_ready   = 1'b0;
      w_wdata_ready = 1'b0;
      w_issue_rd    = 1'b0;
      w_issue_ws    = 1'b0;
      w_issue_blw   = 1'b0;
    end
  end

  assign w_issue        = w_issue_rd || w_issue_ws || w_issue_blw;
  assign w_req_xfer     = w_req_ready && req_valid && w_req_legal;
  assign w_collect_xfer = (r_state == S_COLLECT) && wdata_valid && !reset;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_collect_xfer)
      r_buf[r_idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_cmd  <= 3'd0;
      r_req_addr <= 26'd0;
      r_req_sz   <= 2'd0;
      r_req_op   <= 3'd0;
      r_idx      <= 5'd0;
      r_cmd      <= NOP_CMD;
      r_addr     <= 26'd0;
      r_sz       <= 2'd0;
      r_op       <= 3'd0;
      r_din      <= 16'd0;
    end else begin
      // default keeps every command strictly one cycle wide
      r_cmd <= NOP_CMD;
      if (w_req_xfer) begin
        r_req_cmd  <= req_cmd;
        r_req_addr <= req_addr;
        r_req_sz   <= req_sz;
        r_req_op   <= req_op;
        r_idx      <= 5'd0;
      end
      if (w_collect_xfer)
        r_idx <= r_idx + 5'd1;
      if (w_issue) begin
        r_cmd  <= r_req_cmd;
        r_addr <= r_req_addr;
        r_sz   <= r_req_sz;
        r_op   <= r_req_op;
      end
      if (w_issue_ws)
        r_din <= wdata;
      if (w_issue_blw) begin
        r_din <= r_buf[0];
        r_idx <= 5'd1;
      end
      // a full data FIFO re-presents the current word instead of advancing
      if (r_state == S_BURST) begin
        r_din <= r_buf[r_idx];
        if (!w_fifo_full && !w_last_idx)
          r_idx <= r_idx + 5'd1;
      end
    end
  end

  // validout is registered in the controller, so it is stale right after a pop
  assign w_pop = validout && !r_read_d && (!r_rsp_valid || rsp_ready) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_d    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'd0;
      r_rsp_addr  <= 26'd0;
    end else begin
      r_read_d <= w_pop;
      if (w_pop) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= dout;
        r_rsp_addr  <= raddr;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req_ready   = w_req_ready;
  assign wdata_ready = w_wdata_ready;
  assign cmd         = r_cmd;
  assign addr        = r_addr;
  assign sz          = r_sz;
  assign op          = r_op;
  assign din         = r_din;
  assign read        = w_pop;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_addr    = r_rsp_addr;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_host_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr3_host_port
//  Function : Self-checking bench for ddr3_host_port with a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_host_port;

  localparam logic [2:0] NOP = 3'b000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [25:0] req_addr;
  logic [1:0]  req_sz;
  logic [2:0]  req_op;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [15:0] wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [25:0] rsp_addr;
  logic [2:0]  cmd;
  logic [25:0] addr;
  logic [1:0]  sz;
  logic [2:0]  op;
  logic [15:0] din;
  logic        ready;
  logic        notfull;
  logic [5:0]  fillcount;
  logic        validout;
  logic [15:0] dout;
  logic [25:0] raddr;
  logic        read;

  int n_chk  = 0;
  int n_fail = 0;

  ddr3_host_port #(.NOP_CMD(NOP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_sz(req_sz), .req_op(req_op),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr),
    .cmd(cmd), .addr(addr), .sz(sz), .op(op), .din(din),
    .ready(ready), .notfull(notfull), .fillcount(fillcount),
    .validout(validout), .dout(dout), .raddr(raddr), .read(read)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete command transaction, checked cycle by cycle against the
  // protocol rules: collect phase, issue conditions and burst presentation.
  task automatic run_cmd(input logic [2:0] code, input logic [25:0] a,
                         input logic [1:0] s, input logic [2:0] o,
                         input bit rnd, input int nf_delay, input bit stall,
                         input int abort_idx, input bit seq_words);
    logic [15:0] words [32];
    logic [15:0] wd;
    int n, k, cyc, p;
    bit is_blw, is_rd, is_wr, iss, done;
    n = (s + 1) * 8;
    for (int i = 0; i < 32; i++)
      words[i] = seq_words ? 16'(16'h0100 + i) : 16'($urandom);
    is_blw = (code == 3'd4);
    is_rd  = (code == 3'd1) || (code == 3'd3);
    is_wr  = (code == 3'd2) || (code == 3'd5) || (code == 3'd6);

    req_valid = 1'b1; req_cmd = code; req_addr = a; req_sz = s; req_op = o;
    #1;
    check("req_ready_idle", req_ready, 1'b1);
    step();
    req_valid = 1'b0; req_cmd = 3'd0;

    if (is_blw) begin
      k = 0; cyc = 0;
      while (k < n && cyc < 400) begin
        wdata_valid = rnd ? ($urandom % 4 != 0) : 1'b1;
        wdata = words[k];
        #1;
        check("collect_wready", wdata_ready, 1'b1);
        check("collect_cmd", cmd, NOP);
        step();
        if (wdata_valid) k++;
        cyc++;
      end
      wdata_valid = 1'b0;
      if (k < n) check("collect_timeout", k, n);
    end

    cyc = 0; iss = 1'b0;
    while (!iss && cyc < 100) begin
      if (rnd) begin
        notfull     = ($urandom % 3 != 0);
        fillcount   = ($urandom % 3 == 0) ? 6'd32 : 6'($urandom_range(0, 31));
        wdata_valid = $urandom % 2;
      end else begin
        notfull     = (cyc >= nf_delay);
        fillcount   = 6'd5;
        wdata_valid = 1'b1;
      end
      wd = 16'($urandom);
      wdata = wd;
      #1;
      iss = notfull && (is_rd || (fillcount < 32 && (is_blw || wdata_valid)));
      check("issue_wready", wdata_ready, is_wr && iss);
      step();
      cyc++;
      check("issue_cmd", cmd, iss ? code : NOP);
    end
    wdata_valid = 1'b0;
    if (!iss) begin
      check("issue_timeout", iss, 1'b1);
    end else begin
      check("issue_addr", addr, a);
      check("issue_sz", sz, s);
      check("issue_op", op, o);
      if (is_wr)  check("issue_din_single", din, wd);
      if (is_blw) check("issue_din_first", din, words[0]);
    end

    if (is_blw && iss) begin
      p = 1; done = 1'b0; cyc = 0;
      while (!done && cyc < 400) begin
        if (abort_idx != 0 && p == abort_idx) return;
        if (rnd) begin
          fillcount = ($urandom % 3 == 0) ? 6'd32 : 6'($urandom_range(0, 31));
          notfull   = $urandom % 2;
          ready     = $urandom % 2;
        end else begin
          fillcount = (stall && cyc >= 2 && cyc < 5) ? 6'd32 : 6'd5;
        end
        step();
        cyc++;
        check("burst_cmd", cmd, NOP);
        check("burst_din", din, words[p]);
        if (fillcount != 6'd32) begin
          if (p == n - 1) done = 1'b1;
          else p++;
        end
      end
      if (!done) check("burst_timeout", done, 1'b1);
    end

    ready = 1'b1; notfull = 1'b1; fillcount = 6'd5;
    #1;
    check("back_to_idle", req_ready, 1'b1);
    step();
    check("post_cmd_nop", cmd, NOP);
  endtask

  // Controller return FIFO model: a pop leaves validout stale for one cycle,
  // then the next head (or empty) becomes visible.
  task automatic run_ret(input int nent, input bit rnd_ready);
    logic [15:0] qd [$];
    logic [25:0] qa [$];
    logic [15:0] exp_d;
    logic [25:0] exp_a;
    bit exp_v, stale, allowed;
    int cyc;
    for (int i = 0; i < nent; i++) begin
      qd.push_back(16'($urandom));
      qa.push_back(26'($urandom));
    end
    exp_v = 1'b0; stale = 1'b0; cyc = 0; exp_d = '0; exp_a = '0;
    while ((qd.size() > 0 || exp_v) && cyc < 300) begin
      if (!stale) begin
        if (qd.size() > 0) begin
          validout = 1'b1; dout = qd[0]; raddr = qa[0];
        end else begin
          validout = 1'b0;
        end
      end
      rsp_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
      #1;
      allowed = validout && !stale && (!exp_v || rsp_ready);
      check("ret_read", read, allowed);
      step();
      cyc++;
      if (allowed) begin
        exp_v = 1'b1;
        exp_d = qd.pop_front();
        exp_a = qa.pop_front();
      end else if (rsp_ready) begin
        exp_v = 1'b0;
      end
      stale = allowed;
      check("ret_rsp_valid", rsp_valid, exp_v);
      if (exp_v) begin
        check("ret_rsp_data", rsp_data, exp_d);
        check("ret_rsp_addr", rsp_addr, exp_a);
      end
    end
    if (qd.size() > 0 || exp_v) check("ret_timeout", qd.size(), 0);
    validout = 1'b0; rsp_ready = 1'b0;
    #1;
    check("ret_read_idle", read, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_cmd = 3'd1; req_addr = '0; req_sz = '0;
    req_op = '0; wdata_valid = 1'b1; wdata = 16'hABCD; rsp_ready = 1'b0;
    ready = 1'b1; notfull = 1'b1; fillcount = 6'd0; validout = 1'b1;
    dout = 16'h5555; raddr = 26'h1;

    step(); step();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_wdata_ready", wdata_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_read", read, 1'b0);
    check("rst_cmd", cmd, NOP);
    check("rst_addr", addr, 26'd0);
    check("rst_sz", sz, 2'd0);
    check("rst_op", op, 3'd0);
    check("rst_din", din, 16'd0);
    check("rst_rsp_data", rsp_data, 16'd0);
    check("rst_rsp_addr", rsp_addr, 26'd0);

    reset = 1'b0; req_valid = 1'b0; wdata_valid = 1'b0; validout = 1'b0;
    fillcount = 6'd5;
    step();

    // single read, burst write with ordered data, stalled burst, delayed write
    run_cmd(3'd1, 26'h0000123, 2'd0, 3'd0, 1'b0, 0, 1'b0, 0, 1'b0);
    run_cmd(3'd4, 26'h0000400, 2'd1, 3'd2, 1'b0, 0, 1'b0, 0, 1'b1);
    run_cmd(3'd4, 26'h0000800, 2'd0, 3'd1, 1'b0, 0, 1'b1, 0, 1'b0);
    run_cmd(3'd2, 26'h0000777, 2'd0, 3'd3, 1'b0, 4, 1'b0, 0, 1'b0);
    run_cmd(3'd3, 26'h3FFFFFF, 2'd3, 3'd7, 1'b0, 0, 1'b0, 0, 1'b0);
    run_cmd(3'd5, 26'h0001000, 2'd0, 3'd5, 1'b0, 1, 1'b0, 0, 1'b0);
    run_cmd(3'd6, 26'h0002000, 2'd0, 3'd6, 1'b0, 0, 1'b0, 0, 1'b0);
    run_cmd(3'd4, 26'h0003000, 2'd3, 3'd0, 1'b0, 0, 1'b0, 0, 1'b0);

    // illegal codes are dropped without leaving IDLE
    for (int c = 0; c < 2; c++) begin
      req_valid = 1'b1; req_cmd = (c == 0) ? 3'd0 : 3'd7; wdata_valid = 1'b1;
      step();
      req_valid = 1'b0; req_cmd = 3'd0;
      for (int j = 0; j < 3; j++) begin
        #1;
        check("illegal_req_ready", req_ready, 1'b1);
        check("illegal_wready", wdata_ready, 1'b0);
        step();
        check("illegal_cmd", cmd, NOP);
      end
      wdata_valid = 1'b0;
    end

    // ready low blocks acceptance only
    ready = 1'b0; req_valid = 1'b1; req_cmd = 3'd1;
    for (int j = 0; j < 3; j++) begin
      #1;
      check("notready_req_ready", req_ready, 1'b0);
      step();
      check("notready_cmd", cmd, NOP);
    end
    req_valid = 1'b0; req_cmd = 3'd0; ready = 1'b1;

    // return path: back-to-back entries, then random consumer back-pressure
    run_ret(3, 1'b0);
    run_ret(8, 1'b1);

    // randomized command traffic
    for (int t = 0; t < 14; t++)
      run_cmd(3'($urandom_range(1, 6)), 26'($urandom), 2'($urandom),
              3'($urandom), 1'b1, 0, 1'b0, 0, 1'b0);

    // reset in the middle of collecting burst data
    req_valid = 1'b1; req_cmd = 3'd4; req_sz = 2'd0; req_addr = 26'h55;
    step();
    req_valid = 1'b0; req_cmd = 3'd0;
    for (int j = 0; j < 3; j++) begin
      wdata_valid = 1'b1; wdata = 16'($urandom);
      step();
    end
    reset = 1'b1;
    step();
    check("rstcol_wready", wdata_ready, 1'b0);
    check("rstcol_cmd", cmd, NOP);
    reset = 1'b0;
    for (int j = 0; j < 12; j++) begin
      #1;
      check("rstcol_idle_wready", wdata_ready, 1'b0);
      check("rstcol_idle_rready", req_ready, 1'b1);
      step();
      check("rstcol_idle_cmd", cmd, NOP);
    end
    wdata_valid = 1'b0;
    run_cmd(3'd1, 26'h0000042, 2'd1, 3'd1, 1'b0, 0, 1'b0, 0, 1'b0);

    // reset while the burst is at index 4
    run_cmd(3'd4, 26'h0000900, 2'd0, 3'd0, 1'b0, 0, 1'b0, 4, 1'b0);
    reset = 1'b1; fillcount = 6'd5;
    step();
    check("rstb_cmd", cmd, NOP);
    check("rstb_din", din, 16'd0);
    check("rstb_rsp_valid", rsp_valid, 1'b0);
    check("rstb_req_ready", req_ready, 1'b0);
    reset = 1'b0;
    for (int j = 0; j < 10; j++) begin
      #1;
      check("rstb_idle_wready", wdata_ready, 1'b0);
      check("rstb_idle_read", read, 1'b0);
      step();
      check("rstb_idle_cmd", cmd, NOP);
      check("rstb_idle_din", din, 16'd0);
    end
    run_cmd(3'd4, 26'h0000A00, 2'd2, 3'd4, 1'b1, 0, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
